// File: rtl/ex_mem_pipe.sv
// EX/MEM pipeline register built as a two-entry skid buffer (main + skid).
// Latency: one cycle from accept into an empty block to the outputs.
// Backpressure: in_ready is the registered inverse of skid valid, with no comb path from out_ready.
//
// Ports:
//   clk, rst                       clock, asynchronous active-high reset
//   flush                          synchronous kill of both held entries and any offered input
//   in_valid/in_ready              upstream handshake
//   in_ctrl/in_result/in_fwd/in_rd upstream payload (ctrl bit 0 = regwrite, bit 2 = memwrite)
//   out_valid/out_ready            downstream handshake
//   out_ctrl/out_result/out_fwd/out_rd  head payload, forced to zero while out_valid is low
//   stall_cnt                      saturating count of cycles with out_valid high and out_ready low
module ex_mem_pipe #(
   parameter int DW = 32,
   parameter int AW = 5,
   parameter int CW = 5,
   parameter int SW = 16
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          flush,
   input  logic          in_valid,
   output logic          in_ready,
   input  logic [CW-1:0] in_ctrl,
   input  logic [DW-1:0] in_result,
   input  logic [DW-1:0] in_fwd,
   input  logic [AW-1:0] in_rd,
   input  logic          out_ready,
   output logic          out_valid,
   output logic [CW-1:0] out_ctrl,
   output logic [DW-1:0] out_result,
   output logic [DW-1:0] out_fwd,
   output logic [AW-1:0] out_rd,
   output logic [SW-1:0] stall_cnt
);

   typedef struct packed {
      logic [CW-1:0] ctrl;
      logic [DW-1:0] result;
      logic [DW-1:0] fwd;
      logic [AW-1:0] rd;
   } entry_t;

   entry_t main_q;
   entry_t skid_q;
   entry_t in_e;
   entry_t out_e;
   logic   main_vld;
   logic   skid_vld;
   logic   accept;
   logic   drain;
   logic   main_free;

   assign in_e      = '{ctrl: in_ctrl, result: in_result, fwd: in_fwd, rd: in_rd};
   assign in_ready  = ~skid_vld;
   assign accept    = in_valid & in_ready & ~flush;
   assign drain     = main_vld & out_ready;
   assign main_free = ~main_vld | drain;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         main_vld <= 1'b0;
         skid_vld <= 1'b0;
         main_q   <= '0;
         skid_q   <= '0;
      end else if (flush) begin
         // Payloads keep their contents; only the valid bits are killed.
         main_vld <= 1'b0;
         skid_vld <= 1'b0;
      end else if (main_free) begin
         if (skid_vld) begin
            // Older skid entry goes first; a simultaneous accept refills skid.
            main_q   <= skid_q;
            main_vld <= 1'b1;
            skid_vld <= accept;
            if (accept) begin
               skid_q <= in_e;
            end
         end else if (accept) begin
            main_q   <= in_e;
            main_vld <= 1'b1;
         end else begin
            main_vld <= 1'b0;
         end
      end else if (accept) begin
         // Main is held by downstream: park the new entry in skid.
         skid_q   <= in_e;
         skid_vld <= 1'b1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         stall_cnt <= '0;
      end else if (main_vld && !out_ready && (stall_cnt != {SW{1'b1}})) begin
         stall_cnt <= stall_cnt + SW'(1);
      end
   end

   // Bubble is presented as all-zero so hazard/forwarding logic sees no write.
   assign out_valid  = main_vld;
   assign out_e      = main_vld ? main_q : '0;
   assign out_ctrl   = out_e.ctrl;
   assign out_result = out_e.result;
   assign out_fwd    = out_e.fwd;
   assign out_rd     = out_e.rd;

endmodule

// File: tb/tb_ex_mem_pipe.sv
module tb_ex_mem_pipe;

   logic        clk, rst, flush, in_valid, out_ready;
   logic [4:0]  in_ctrl, in_rd;
   logic [31:0] in_result, in_fwd;
   logic        in_ready, out_valid;
   logic [4:0]  out_ctrl, out_rd;
   logic [31:0] out_result, out_fwd;
   logic [15:0] stall_cnt;

   logic        s_in_ready, s_out_valid;
   logic [4:0]  s_out_ctrl, s_out_rd;
   logic [31:0] s_out_result, s_out_fwd;
   logic [2:0]  s_stall_cnt;

   int checks = 0;
   int failures = 0;

   ex_mem_pipe #(.DW(32), .AW(5), .CW(5), .SW(16)) dut (
      .clk(clk), .rst(rst), .flush(flush),
      .in_valid(in_valid), .in_ready(in_ready),
      .in_ctrl(in_ctrl), .in_result(in_result), .in_fwd(in_fwd), .in_rd(in_rd),
      .out_ready(out_ready), .out_valid(out_valid),
      .out_ctrl(out_ctrl), .out_result(out_result), .out_fwd(out_fwd), .out_rd(out_rd),
      .stall_cnt(stall_cnt)
   );

   // Narrow stall counter instance, driven by the same inputs, for saturation.
   ex_mem_pipe #(.DW(32), .AW(5), .CW(5), .SW(3)) dut_sat (
      .clk(clk), .rst(rst), .flush(flush),
      .in_valid(in_valid), .in_ready(s_in_ready),
      .in_ctrl(in_ctrl), .in_result(in_result), .in_fwd(in_fwd), .in_rd(in_rd),
      .out_ready(out_ready), .out_valid(s_out_valid),
      .out_ctrl(s_out_ctrl), .out_result(s_out_result), .out_fwd(s_out_fwd), .out_rd(s_out_rd),
      .stall_cnt(s_stall_cnt)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Advance to just after the next rising edge.
   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic v, input logic [4:0] c, input logic [31:0] r,
                        input logic [31:0] f, input logic [4:0] d);
      in_valid  = v;
      in_ctrl   = c;
      in_result = r;
      in_fwd    = f;
      in_rd     = d;
   endtask

   task automatic do_reset();
      rst = 1'b1; flush = 1'b0; out_ready = 1'b0;
      drive(1'b0, 5'd0, 32'd0, 32'd0, 5'd0);
      cyc();
      rst = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1; flush = 1'b0; out_ready = 1'b1;
      drive(1'b1, 5'h1f, 32'hdead_beef, 32'h1234_5678, 5'd3);
      cyc();
      checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid got=%0h exp=0", out_valid); end
      checks++; if ({out_ctrl, out_result, out_fwd, out_rd} !== 74'd0) begin failures++; $display("FAIL reset_payload got=%0h exp=0", {out_ctrl, out_result, out_fwd, out_rd}); end
      checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL reset_in_ready got=%0h exp=1", in_ready); end
      checks++; if (stall_cnt !== 16'd0) begin failures++; $display("FAIL reset_stall got=%0d exp=0", stall_cnt); end
      // First edge after release accepts input.
      rst = 1'b0;
      cyc();
      checks++; if (out_valid !== 1'b1 || out_result !== 32'hdead_beef) begin failures++; $display("FAIL reset_first_accept got=%0h/%0h exp=1/deadbeef", out_valid, out_result); end
      drive(1'b0, 5'd0, 32'd0, 32'd0, 5'd0);
   endtask

   task automatic test_single_pass();
      do_reset();
      out_ready = 1'b1;
      drive(1'b1, 5'b00001, 32'h0000_00aa, 32'h0000_0055, 5'd7);
      cyc();
      drive(1'b0, 5'd0, 32'd0, 32'd0, 5'd0);
      checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL single_valid got=%0h exp=1", out_valid); end
      checks++; if (out_result !== 32'haa) begin failures++; $display("FAIL single_result got=%0h exp=aa", out_result); end
      checks++; if (out_rd !== 5'd7) begin failures++; $display("FAIL single_rd got=%0d exp=7", out_rd); end
      checks++; if (out_ctrl[0] !== 1'b1 || out_ctrl !== 5'b00001) begin failures++; $display("FAIL single_ctrl got=%0b exp=00001", out_ctrl); end
      checks++; if (out_fwd !== 32'h55) begin failures++; $display("FAIL single_fwd got=%0h exp=55", out_fwd); end
      cyc();
      checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL single_bubble_valid got=%0h exp=0", out_valid); end
      checks++; if ({out_ctrl, out_result, out_fwd, out_rd} !== 74'd0) begin failures++; $display("FAIL single_bubble_payload got=%0h exp=0", {out_ctrl, out_result, out_fwd, out_rd}); end
   endtask

   task automatic test_back_pressure();
      do_reset();
      out_ready = 1'b0;
      drive(1'b1, 5'd1, 32'h0a, 32'h1a, 5'd1);   // A
      cyc();
      checks++; if (out_valid !== 1'b1 || out_result !== 32'h0a || stall_cnt !== 16'd0 || in_ready !== 1'b1) begin failures++; $display("FAIL bp_a_loaded got=%0h/%0h/%0d/%0h exp=1/a/0/1", out_valid, out_result, stall_cnt, in_ready); end
      drive(1'b1, 5'd2, 32'h0b, 32'h1b, 5'd2);   // B
      cyc();
      checks++; if (out_result !== 32'h0a || in_ready !== 1'b0 || stall_cnt !== 16'd1) begin failures++; $display("FAIL bp_b_skid got=%0h/%0h/%0d exp=a/0/1", out_result, in_ready, stall_cnt); end
      drive(1'b1, 5'd3, 32'h0c, 32'h1c, 5'd3);   // C, held upstream
      cyc();
      checks++; if (out_result !== 32'h0a || out_fwd !== 32'h1a || in_ready !== 1'b0 || stall_cnt !== 16'd2) begin failures++; $display("FAIL bp_hold got=%0h/%0h/%0h/%0d exp=a/1a/0/2", out_result, out_fwd, in_ready, stall_cnt); end
      out_ready = 1'b1;
      checks++; if (out_valid !== 1'b1 || out_rd !== 5'd1) begin failures++; $display("FAIL bp_deliver_a got=%0h/%0d exp=1/1", out_valid, out_rd); end
      cyc();
      checks++; if (out_valid !== 1'b1 || out_result !== 32'h0b || out_rd !== 5'd2 || stall_cnt !== 16'd2) begin failures++; $display("FAIL bp_deliver_b got=%0h/%0h/%0d/%0d exp=1/b/2/2", out_valid, out_result, out_rd, stall_cnt); end
      cyc();
      drive(1'b0, 5'd0, 32'd0, 32'd0, 5'd0);
      checks++; if (out_valid !== 1'b1 || out_result !== 32'h0c || out_ctrl !== 5'd3) begin failures++; $display("FAIL bp_deliver_c got=%0h/%0h/%0d exp=1/c/3", out_valid, out_result, out_ctrl); end
      cyc();
      checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL bp_empty got=%0h exp=0", out_valid); end
   endtask

   task automatic test_flush();
      do_reset();
      out_ready = 1'b0;
      drive(1'b1, 5'd1, 32'h0a, 32'h1a, 5'd1);
      cyc();
      drive(1'b1, 5'd2, 32'h0b, 32'h1b, 5'd2);
      cyc();
      // Both full, stall_cnt = 1. Flush with D offered.
      flush = 1'b1; out_ready = 1'b1;
      drive(1'b1, 5'd4, 32'h0d, 32'h1d, 5'd4);
      cyc();
      flush = 1'b0;
      drive(1'b0, 5'd0, 32'd0, 32'd0, 5'd0);
      checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin failures++; $display("FAIL flush_full got=%0h/%0h exp=0/1", out_valid, in_ready); end
      checks++; if (stall_cnt !== 16'd1) begin failures++; $display("FAIL flush_stall got=%0d exp=1", stall_cnt); end
      cyc();
      checks++; if (out_valid !== 1'b0 || out_result !== 32'd0) begin failures++; $display("FAIL flush_no_d got=%0h/%0h exp=0/0", out_valid, out_result); end
      // Main only, in_ready = 1: offered E must also be discarded.
      drive(1'b1, 5'd5, 32'h0e, 32'h1e, 5'd5);
      out_ready = 1'b0;
      cyc();
      flush = 1'b1;
      drive(1'b1, 5'd6, 32'h0f, 32'h1f, 5'd6);
      cyc();
      flush = 1'b0;
      drive(1'b0, 5'd0, 32'd0, 32'd0, 5'd0);
      checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL flush_main_only got=%0h exp=0", out_valid); end
      cyc();
      checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL flush_input_dropped got=%0h exp=0", out_valid); end
   endtask

   task automatic test_saturation();
      do_reset();
      out_ready = 1'b0;
      drive(1'b1, 5'd1, 32'h77, 32'h0, 5'd9);
      cyc();
      drive(1'b0, 5'd0, 32'd0, 32'd0, 5'd0);
      for (int i = 0; i < 7; i++) cyc();
      checks++; if (s_stall_cnt !== 3'd7) begin failures++; $display("FAIL sat_reach got=%0d exp=7", s_stall_cnt); end
      for (int i = 0; i < 3; i++) cyc();
      checks++; if (s_stall_cnt !== 3'd7) begin failures++; $display("FAIL sat_hold got=%0d exp=7", s_stall_cnt); end
      checks++; if (stall_cnt !== 16'd10) begin failures++; $display("FAIL sat_wide got=%0d exp=10", stall_cnt); end
      checks++; if (out_result !== 32'h77 || out_rd !== 5'd9) begin failures++; $display("FAIL sat_stable got=%0h/%0d exp=77/9", out_result, out_rd); end
   endtask

   task automatic test_async_reset();
      do_reset();
      out_ready = 1'b0;
      drive(1'b1, 5'd1, 32'h0a, 32'h1a, 5'd1);
      cyc();
      drive(1'b1, 5'd2, 32'h0b, 32'h1b, 5'd2);
      cyc();
      drive(1'b0, 5'd0, 32'd0, 32'd0, 5'd0);
      #2 rst = 1'b1;
      #1;
      checks++; if (out_valid !== 1'b0 || out_rd !== 5'd0 || stall_cnt !== 16'd0 || in_ready !== 1'b1) begin failures++; $display("FAIL async_rst got=%0h/%0d/%0d/%0h exp=0/0/0/1", out_valid, out_rd, stall_cnt, in_ready); end
      #1 rst = 1'b0;
      out_ready = 1'b1;
      drive(1'b1, 5'd1, 32'hf0, 32'h0, 5'd11);
      cyc();
      drive(1'b0, 5'd0, 32'd0, 32'd0, 5'd0);
      checks++; if (out_valid !== 1'b1 || out_result !== 32'hf0 || out_rd !== 5'd11) begin failures++; $display("FAIL async_first_edge got=%0h/%0h/%0d exp=1/f0/11", out_valid, out_result, out_rd); end
   endtask

   task automatic test_random_stream();
      logic [73:0] q[$];
      logic [73:0] got;
      int          pre;
      do_reset();
      for (int n = 0; n < 1010; n++) begin
         if (n < 1000) begin
            drive(1'($urandom_range(0, 1)), 5'($urandom), $urandom, $urandom, 5'($urandom));
            out_ready = 1'($urandom_range(0, 1));
         end else begin
            drive(1'b0, 5'd0, 32'd0, 32'd0, 5'd0);
            out_ready = 1'b1;
         end
         got = {out_ctrl, out_result, out_fwd, out_rd};
         checks++; if (in_ready !== (q.size() < 2)) begin failures++; $display("FAIL rnd_in_ready cyc=%0d got=%0h exp=%0h", n, in_ready, q.size() < 2); end
         checks++; if (out_valid !== (q.size() > 0)) begin failures++; $display("FAIL rnd_out_valid cyc=%0d got=%0h exp=%0h", n, out_valid, q.size() > 0); end
         if (q.size() > 0) begin
            checks++; if (got !== q[0]) begin failures++; $display("FAIL rnd_payload cyc=%0d got=%0h exp=%0h", n, got, q[0]); end
         end else begin
            checks++; if (got !== 74'd0) begin failures++; $display("FAIL rnd_bubble cyc=%0d got=%0h exp=0", n, got); end
         end
         pre = q.size();
         if (out_ready && pre > 0) void'(q.pop_front());
         if (in_valid && pre < 2) q.push_back({in_ctrl, in_result, in_fwd, in_rd});
         cyc();
      end
      checks++; if (q.size() != 0 || out_valid !== 1'b0) begin failures++; $display("FAIL rnd_drained got=%0d/%0h exp=0/0", q.size(), out_valid); end
   endtask

   initial begin
      test_reset();
      test_single_pass();
      test_back_pressure();
      test_flush();
      test_saturation();
      test_async_reset();
      test_random_stream();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/ex_mem_pipe.md
EX_MEM_PIPE -- requirements
Module: ex_mem_pipe

Interface
REQ-001 The module SHALL expose parameter DW, default 32, meaning width of the result and forward-data payload fields.
REQ-002 The module SHALL expose parameter AW, default 5, meaning width of the destination register index.
REQ-003 The module SHALL expose parameter CW, default 5, meaning number of control bits carried, with bit 0 = regwrite and bit 2 = memwrite.
REQ-004 The module SHALL expose parameter SW, default 16, meaning width of the stall counter.
REQ-005 Port clk, input, 1 bit: single clock; all state SHALL update on its rising edge.
REQ-006 Port rst, input, 1 bit: reset, asynchronous and active-high.
REQ-007 Port flush, input, 1 bit: synchronous kill of all held entries.
REQ-008 Port in_valid, input, 1 bit: upstream entry present.
REQ-009 Port in_ready, output, 1 bit: entry can be accepted this cycle.
REQ-010 Ports in_ctrl [CW], in_result [DW], in_fwd [DW] and in_rd [AW], inputs: upstream payload.
REQ-011 Port out_ready, input, 1 bit: downstream accepts the head entry.
REQ-012 Port out_valid, output, 1 bit: head entry present.
REQ-013 Ports out_ctrl [CW], out_result [DW], out_fwd [DW] and out_rd [AW], outputs: head payload.
REQ-014 Port stall_cnt, output, SW bits: saturating count of back-pressured cycles.

Function
REQ-015 Storage SHALL be two entries, main (drives the outputs) and skid, each holding a valid bit and a payload.
REQ-016 in_ready SHALL equal NOT skid.valid, driven from a register with no combinational path from out_ready.
REQ-017 An accept SHALL occur when in_valid = 1, in_ready = 1 and flush = 0.
REQ-018 A drain SHALL occur when out_valid = 1 and out_ready = 1.
REQ-019 When main is empty or draining, main SHALL load from skid if skid is valid; otherwise it SHALL load the accepted input; otherwise it SHALL become empty.
REQ-020 An accept while main is full and not draining SHALL write the input into skid.
REQ-021 An accept in the same cycle that skid moves into main SHALL write the input into skid.
REQ-022 Ordering SHALL be strict FIFO: no entry may overtake another, be duplicated or be lost except by flush.
REQ-023 Latency SHALL be one cycle: an input accepted into an empty block appears on the outputs at the next edge.
REQ-024 Throughput SHALL be one entry per cycle while out_ready = 1.
REQ-025 flush = 1 SHALL clear both valid bits at the edge and discard any input offered that cycle.
REQ-026 flush SHALL take priority over accept and drain, and its effect SHALL be visible the next cycle.
REQ-027 When out_valid = 0, out_ctrl, out_rd, out_result and out_fwd SHALL read 0, so hazard and forwarding logic see a bubble.
REQ-028 When out_valid = 1, the out_* ports SHALL carry the main payload unmodified at full width.
REQ-029 stall_cnt SHALL increment each cycle that out_valid = 1 and out_ready = 0.
REQ-030 stall_cnt SHALL saturate at 2^SW - 1 and SHALL NOT wrap.
REQ-031 stall_cnt SHALL clear only on rst, not on flush.
REQ-032 Payload registers not being loaded SHALL hold their value, and the main payload SHALL stay stable while out_valid = 1 and out_ready = 0.

Reset
REQ-033 While rst = 1, main.valid and skid.valid SHALL be 0, all payload registers 0, stall_cnt 0, out_valid 0, all out_* ports 0 and in_ready 1.
REQ-034 Reset asserted mid-transfer SHALL discard all entries immediately, with no transfer completing on that edge.
REQ-035 After rst deasserts, the first rising edge SHALL accept input normally.

Verification
REQ-036 Directed test, single pass: rst pulse, then in_valid = 1, in_result = 0x0000_00AA, in_rd = 5'd7, in_ctrl = 5'b00001, out_ready = 1 for one cycle -> next cycle out_valid = 1, out_result = 0xAA, out_rd = 7, out_ctrl[0] = 1; the following cycle out_valid = 0 and all out_* = 0.
REQ-037 Directed test, back-pressure: stream A, B, C with out_ready = 0 -> A held in main, B in skid, in_ready = 0, C held upstream; stall_cnt increments by 1 per cycle; then out_ready = 1 -> A, B, C delivered on consecutive cycles.
REQ-038 Directed test, flush: main and skid full, flush = 1 while in_valid = 1 with D -> next cycle out_valid = 0, in_ready = 1, D never appears, stall_cnt unchanged.
REQ-039 Directed test, saturation: SW = 3, hold out_ready = 0 with main full for 10 cycles -> stall_cnt stops at 7.
REQ-040 Directed test, asynchronous reset: assert rst between edges while both entries are full -> out_valid, out_rd and stall_cnt go to 0 before the next edge and in_ready goes to 1.
REQ-041 Directed test, randomised stream: random in_valid and out_ready over 1000 cycles, compared against a reference queue -> output order and payloads match exactly and no entry is lost.
